jtroadf_prog: RTL



---
 rtl/jtroadf_prog_pkg.sv | 58 +++++
 rtl/jtroadf_prog_fifo.sv | 56 +++++
 rtl/jtroadf_prog.sv | 131 +++++++++++++
 3 files changed

// File: rtl/jtroadf_prog_pkg.sv
// Shared definitions for the Road Fighter ROM download conditioner:
// region decode and tile address swizzle, also usable by sim loaders.
package jtroadf_prog_pkg;

   typedef enum logic [2:0] {
      REG_SCR,
      REG_OBJ,
      REG_PCM,
      REG_OTHER,
      REG_PROM
   } region_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SDWR,
      ST_PROM
   } state_t;

   localparam int ENTRY_W = 33;

   // Region of a byte address; ranges are half-open.
   function automatic region_t region_of(
      input logic [24:0] addr,
      input logic [24:0] scr,
      input logic [24:0] obj,
      input logic [24:0] pcm,
      input logic [24:0] prom
   );
      region_t r;
      if (addr >= prom)
         r = REG_PROM;
      else if (addr >= scr && addr < obj)
         r = REG_SCR;
      else if (addr >= obj && addr < pcm)
         r = REG_OBJ;
      else if (addr >= pcm)
         r = REG_PCM;
      else
         r = REG_OTHER;
      return r;
   endfunction

   // Tile ROM bit reordering on the SDRAM word address.
   function automatic logic [21:0] swizzle(
      input region_t     r,
      input logic [21:0] a
   );
      logic [21:0] s;
      s = a;
      case (r)
         REG_SCR: s[3:0] = {a[2:0], ~a[3]};
         REG_OBJ: s[4:0] = {a[2:0], ~a[4], ~a[3]};
         default: s = a;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/jtroadf_prog_fifo.sv
// Small synchronous FIFO holding {addr, data} download entries.
// Ports: push/din in, pop/dout out (show-ahead), full/empty flags.
module jtroadf_prog_fifo #(
   parameter int AW = 2,
   parameter int W  = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

   logic [W-1:0]  mem [1 << AW];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   cnt;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (cnt == DEPTH);
   assign empty   = (cnt == '0);
   assign pop_ok  = pop & ~empty;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/jtroadf_prog.sv
// ROM download conditioner: ioctl bytes -> FIFO -> SDRAM or PROM writes.
// Ports: ioctl_* in, prog_* / sdram_ack SDRAM side, prom_* PROM side,
// is_hyper flag, dwnld_busy, sticky ovf on dropped bytes.
module jtroadf_prog
   import jtroadf_prog_pkg::*;
#(
   parameter logic [21:0] SCR_START  = 22'h0,
   parameter logic [21:0] OBJ_START  = 22'h0,
   parameter logic [21:0] PCM_START  = 22'h0,
   parameter logic [24:0] PROM_START = 25'h0,
   parameter int          FIFO_AW    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        downloading,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        ioctl_wr,
   output logic [21:0] prog_addr,
   output logic [7:0]  prog_data,
   output logic [1:0]  prog_mask,
   output logic        prog_we,
   input  logic        sdram_ack,
   output logic        prom_we,
   output logic [10:0] prom_addr,
   output logic        is_hyper,
   output logic        dwnld_busy,
   output logic        ovf
);

   localparam logic [24:0] SCR_A   = {3'b0, SCR_START};
   localparam logic [24:0] OBJ_A   = {3'b0, OBJ_START};
   localparam logic [24:0] PCM_A   = {3'b0, PCM_START};
   localparam logic [24:0] HYPER_A = PROM_START + 25'd1;
   localparam logic [10:0] PROM_LO = PROM_START[10:0];

   state_t              state;
   state_t              nxt;
   logic                push;
   logic                pop;
   logic                full;
   logic                empty;
   logic [ENTRY_W-1:0]  head;
   logic [24:0]         head_addr;
   logic [7:0]          head_data;
   region_t             head_reg;
   logic                dl_q;

   assign push = ioctl_wr & downloading;
   assign pop  = (state == ST_IDLE) & ~empty;
   assign {head_addr, head_data} = head;
   assign head_reg = region_of(head_addr, SCR_A, OBJ_A,
                               PCM_A, PROM_START);

   jtroadf_prog_fifo #(
      .AW (FIFO_AW),
      .W  (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({ioctl_addr, ioctl_dout}),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         ST_IDLE:
            if (!empty)
               nxt = (head_reg == REG_PROM) ? ST_PROM : ST_SDWR;
         ST_SDWR:
            if (sdram_ack)
               nxt = ST_IDLE;
         ST_PROM:
            nxt = ST_IDLE;
         default:
            nxt = ST_IDLE;
      endcase
   end

   // Strobes come straight from the state flops
   assign prog_we    = (state == ST_SDWR);
   assign prom_we    = (state == ST_PROM);
   assign dwnld_busy = downloading | ~empty | (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prog_addr <= '0;
         prog_data <= '0;
         prog_mask <= '0;
         prom_addr <= '0;
         is_hyper  <= 1'b0;
      end else if (pop) begin
         if (head_reg == REG_PROM) begin
            prom_addr <= head_addr[10:0] - PROM_LO;
            if (head_addr == HYPER_A)
               is_hyper <= &head_data;
         end else begin
            prog_addr <= swizzle(head_reg, head_addr[22:1]);
            prog_data <= head_data;
            // Even byte goes to the upper lane
            prog_mask <= head_addr[0] ? 2'b10 : 2'b01;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_q <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         dl_q <= downloading;
         if (push & full & ~pop)
            ovf <= 1'b1;
         else if (downloading & ~dl_q)
            ovf <= 1'b0;
      end
   end

endmodule
